lsu_mem_responder: RTL and testbench

- Memory-side responder for the MEM pipeline stage.
- Accepts load/store requests from the pipeline and runs them on a req/gnt/rvalid data bus.
- Returns a one-cycle `valid` pulse, plus sign/zero-extended load data.
- `valid` is the completion signal the hazard logic waits on before releasing a load stall.

---
 rtl/lsu_mem_responder.sv | 241 ++++++++++++++++++++++++
 tb/tb_lsu_mem_responder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the MEM pipeline stage.
//
// Takes a load or store from the MEM stage and runs it on a req/gnt/rvalid data bus. It returns a
// one-cycle completion pulse on `valid` together with sign/zero-extended load data. The hazard
// logic waits on `valid` before it releases a load stall.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum number of cycles spent waiting for bus_rvalid after a grant.
//                   0 disables the timeout.
//
// Optional feature (compile-time macro MISALIGN_CHECK_EN):
//   A half access with addr[0]=1, or a word access with addr[1:0]!=0, completes straight from idle
//   with misalign=1 and never touches the bus. When the macro is undefined, misalign is tied to 0
//   and the low address bits that a wide access does not need are ignored.
//
// Ports:
//   clk, rst_n                     clock (rising edge) and asynchronous active-low reset
//   mem_read, mem_write            MEM-stage load / store; a load wins if both are set
//   funct3, addr, wdata            RISC-V access size/sign, byte address, store data (rs2)
//   flush                          kills the current request
//   valid, rdata, err, misalign    completion pulse and its qualifiers
//   bus_req, bus_we, bus_addr,     bus request channel; all fields are registered at capture so
//   bus_be, bus_wdata              they stay stable while the request is held
//   bus_gnt, bus_rvalid, bus_rdata bus grant and read response
module lsu_mem_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic        start;
  logic        timeout_hit;
`ifdef MISALIGN_CHECK_EN
  logic        misalign_q, misalign_d;
`endif

  // Access size is encoded in funct3[1:0]: 00 byte, 01 half, 1x word.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    unique case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    unique case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    unique case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = w;  // LW and the reserved encodings
    endcase
    return r;
  endfunction

`ifdef MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == 2'b01) && a[0]) || (size[1] && (a != 2'b00));
  endfunction
`endif

  assign start       = (mem_read | mem_write) & ~flush;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
`ifdef MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d   = addr;
          funct3_d = funct3;
          we_d     = ~mem_read;
          be_d     = lane_be(funct3[1:0], addr[1:0]);
          wdata_d  = lane_wdata(funct3[1:0], wdata);
          // Completion qualifiers start clean for every new access.
          rdata_d  = '0;
          err_d    = 1'b0;
`ifdef MISALIGN_CHECK_EN
          misalign_d = is_misaligned(funct3[1:0], addr[1:0]);
          state_d    = misalign_d ? StDone : StReq;
`else
          state_d    = StReq;
`endif
        end
      end
      StReq: begin
        // A flushed request cycle is never a grant, even if bus_gnt is high.
        if (flush) begin
          state_d = StIdle;
        end else if (bus_gnt) begin
          if (we_q) begin
            state_d = StDone;
          end else begin
            state_d = StWait;
            cnt_d   = '0;
          end
        end
      end
      StWait: begin
        if (bus_rvalid) begin
          state_d = StDone;
          rdata_d = load_extend(funct3_q, addr_q[1:0], bus_rdata);
        end else if (flush) begin
          // The read is already in flight; absorb its response before going idle.
          state_d = StDrain;
        end else if (timeout_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDrain: begin
        if (bus_rvalid || timeout_hit) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        // The completing instruction is still in MEM this cycle, so nothing is sampled here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign valid     = (state_q == StDone);
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign bus_req   = (state_q == StReq);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Self-checking bench for lsu_mem_responder. A bus responder grants after a chosen number of
// request cycles and returns read data after a chosen delay. Expected latency, lanes and extended
// data are computed from the access rules with plain arithmetic.
module tb_lsu_mem_responder;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        valid, err, misalign, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  // Observations from the last transaction
  int          o_lat, o_req_cycles;
  logic        o_stable, o_we, o_err, o_mis;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && valid) n_valid++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  lsu_mem_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .flush      (flush),
    .valid      (valid),
    .rdata      (rdata),
    .err        (err),
    .misalign   (misalign),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  task automatic idle(input int n);
    mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Presents one request at the current negedge (cycle 0) and plays the bus. Grants on the g-th
  // request cycle; returns read data r cycles after the cycle following the grant (r<0: never).
  // Flush is driven during cycle flush_at (<0: never); the killed instruction then leaves MEM.
  // Returns at the negedge where valid is seen, request inputs still held, or after 20 cycles.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                         input int g, input int r, input int flush_at);
    int cg;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    flush = (flush_at == 0); bus_gnt = 1'b0; bus_rvalid = 1'b0;
    o_lat = -1; o_req_cycles = 0; o_stable = 1'b1; o_we = 1'b0; o_err = 1'b0; o_mis = 1'b0;
    o_rdata = '0; o_addr = '0; o_wdata = '0; o_be = '0;
    cg = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (flush_at >= 0 && c > flush_at) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end
      flush = (c == flush_at);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (valid) begin
        o_lat = c; o_rdata = rdata; o_err = err; o_mis = misalign;
        break;
      end
      if (bus_req) begin
        if (o_req_cycles == 0) begin
          o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata; o_we = bus_we;
        end else if (bus_addr !== o_addr || bus_be !== o_be || bus_wdata !== o_wdata ||
                     bus_we !== o_we) begin
          o_stable = 1'b0;
        end
        if (o_req_cycles == g) begin
          bus_gnt = 1'b1;
          if (rd) cg = c;
        end
        o_req_cycles++;
      end
      if (cg >= 0 && r >= 0 && c - cg - 1 == r) begin
        bus_rvalid = 1'b1; bus_rdata = rword;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_checks++;
    if ({valid, err, misalign, bus_req, bus_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {valid, err, misalign, bus_req, bus_we});
    end
    n_checks++;
    if (rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    n_checks++;
    if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h be %b wdata %h expected zeros", bus_addr, bus_be,
               bus_wdata);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_lb();
    run_txn(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0011, 0, 0, -1);
    n_checks++;
    if (o_lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", o_lat); end
    n_checks++;
    if (o_rdata !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", o_rdata);
    end
    n_checks++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL lb_err: got %b expected 0", o_err); end
    n_checks++;
    if (o_be !== 4'b1000 || o_addr !== 32'h100 || o_we !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_bus: got be %b addr %h we %b expected 1000 100 0", o_be, o_addr, o_we);
    end
    idle(1);
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL lb_single_pulse: got %b expected 0", valid); end
  endtask

  task automatic test_sh();
    run_txn(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 2, -1, -1);
    n_checks++;
    if (o_lat !== 4) begin n_fail++; $display("FAIL sh_latency: got %0d expected 4", o_lat); end
    n_checks++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD || o_we !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_bus: got be %b wdata %h we %b expected 1100 abcdabcd 1", o_be, o_wdata,
               o_we);
    end
    n_checks++;
    if (o_stable !== 1'b1 || o_req_cycles !== 3) begin
      n_fail++;
      $display("FAIL sh_hold: got stable %b req_cycles %0d expected 1 3", o_stable, o_req_cycles);
    end
    idle(1);
  endtask

  task automatic test_flush_drain();
    logic [31:0] w;
    run_txn(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 2, 2);
    n_checks++;
    if (o_lat !== -1) begin n_fail++; $display("FAIL flush_no_valid: got %0d expected -1", o_lat); end
    n_checks++;
    if (bus_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b expected 0", bus_req); end
    idle(1);
    w = $urandom;
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, w, 0, 0, -1);
    n_checks++;
    if (o_lat !== 3 || o_rdata !== w) begin
      n_fail++;
      $display("FAIL flush_next_lw: got lat %0d rdata %h expected 3 %h", o_lat, o_rdata, w);
    end
    idle(1);
    // Flush in WAIT with no response: the drain times out silently.
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0030, 32'h0, 32'h0, 0, -1, 2);
    n_checks++;
    if (o_lat !== -1) begin n_fail++; $display("FAIL drain_timeout_silent: got %0d expected -1", o_lat); end
    idle(1);
    w = $urandom;
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0034, 32'h0, w, 1, 1, -1);
    n_checks++;
    if (o_lat !== 5 || o_rdata !== w) begin
      n_fail++;
      $display("FAIL drain_then_lw: got lat %0d rdata %h expected 5 %h", o_lat, o_rdata, w);
    end
    // Flush alongside the request in IDLE: nothing is captured.
    idle(1);
    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h1, 32'h0, 0, -1, 0);
    n_checks++;
    if (o_lat !== -1 || o_req_cycles !== 0) begin
      n_fail++;
      $display("FAIL flush_idle_request: got lat %0d req_cycles %0d expected -1 0", o_lat,
               o_req_cycles);
    end
    idle(1);
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'h0, 32'h0, 1, -1, -1);
    n_checks++;
    if (o_lat !== 8) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 8", o_lat); end
    n_checks++;
    if (o_err !== 1'b1 || o_rdata !== 32'h0) begin
      n_fail++; $display("FAIL timeout_err: got err %b rdata %h expected 1 0", o_err, o_rdata);
    end
    idle(1);
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL timeout_single_pulse: got %b expected 0", valid); end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [31:0] w, d;
    n0 = n_valid;
    w = $urandom; d = $urandom;
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0060, 32'h0, w, 0, 0, -1);
    n_checks++;
    if (o_lat !== 3 || o_rdata !== w) begin
      n_fail++; $display("FAIL b2b_lw: got lat %0d rdata %h expected 3 %h", o_lat, o_rdata, w);
    end
    // mem_read is still high across the DONE edge; it must not start a second access.
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_not_sampled: got valid %b req %b expected 0 0", valid, bus_req);
    end
    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_0064, d, 32'h0, 0, -1, -1);
    n_checks++;
    if (o_lat !== 2 || o_we !== 1'b1 || o_wdata !== d || o_be !== 4'b1111) begin
      n_fail++;
      $display("FAIL b2b_sw: got lat %0d we %b wdata %h be %b expected 2 1 %h 1111", o_lat, o_we,
               o_wdata, o_be, d);
    end
    idle(2);
    n_checks++;
    if (n_valid - n0 !== 2) begin
      n_fail++; $display("FAIL b2b_pulse_count: got %0d expected 2", n_valid - n0);
    end
  endtask

  task automatic test_both_set();
    logic [31:0] w;
    w = $urandom;
    run_txn(1'b1, 1'b1, 3'b010, 32'h0000_0070, 32'h5555_5555, w, 0, 1, -1);
    n_checks++;
    if (o_lat !== 4 || o_we !== 1'b0 || o_rdata !== w) begin
      n_fail++;
      $display("FAIL both_read_wins: got lat %0d we %b rdata %h expected 4 0 %h", o_lat, o_we,
               o_rdata, w);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    int n0;
    logic [31:0] w;
    n0 = n_valid;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h80;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0; mem_read = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || valid !== 1'b0 || bus_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got req %b valid %b addr %h expected 0 0 0", bus_req, valid,
               bus_addr);
    end
    @(negedge clk);
    rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_rvalid = 1'b0;
    idle(4);
    n_checks++;
    if (n_valid - n0 !== 0) begin
      n_fail++; $display("FAIL reset_mid_stale_rvalid: got %0d pulses expected 0", n_valid - n0);
    end
    w = $urandom;
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0084, 32'h0, w, 0, 0, -1);
    n_checks++;
    if (o_lat !== 3 || o_rdata !== w) begin
      n_fail++; $display("FAIL reset_mid_recover: got lat %0d rdata %h expected 3 %h", o_lat, o_rdata, w);
    end
    idle(1);
  endtask

`ifdef MISALIGN_CHECK_EN
  task automatic test_misalign();
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0, -1);
    n_checks++;
    if (o_lat !== 1 || o_mis !== 1'b1 || o_req_cycles !== 0 || o_rdata !== 32'h0 || o_err !== 1'b0)
    begin
      n_fail++;
      $display("FAIL misalign_lw: got lat %0d mis %b req %0d rdata %h err %b expected 1 1 0 0 0",
               o_lat, o_mis, o_req_cycles, o_rdata, o_err);
    end
    idle(1);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      logic        rd, wr, exp_mis, sgn;
      logic [2:0]  f3;
      logic [31:0] a, wd, rw, mask, exp_rd, exp_wd;
      logic [3:0]  exp_be;
      int          g, r, sz, off, exp_lat;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = rd ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      a = $urandom; wd = $urandom; rw = $urandom;
      g = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 3));
      sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off  = int'(a[1:0]) & ~(sz - 1);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      exp_be = 4'(((1 << sz) - 1) << off);
      exp_wd = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
               (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      exp_rd = (rw >> (8 * off)) & mask;
      sgn = (f3 == 3'b000) || (f3 == 3'b001);
      if (sgn && exp_rd[8 * sz - 1]) exp_rd = exp_rd | ~mask;
      exp_lat = rd ? 3 + g + r : 2 + g;
      exp_mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
      if ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00)) begin
        exp_mis = 1'b1; exp_lat = 1; exp_rd = '0;
      end
`endif
      run_txn(rd, wr, f3, a, wd, rw, g, r, -1);
      n_checks++;
      if (o_lat !== exp_lat || o_mis !== exp_mis || o_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_completion[%0d]: got lat %0d mis %b err %b expected %0d %b 0", i,
                 o_lat, o_mis, o_err, exp_lat, exp_mis);
      end
      if (exp_mis) begin
        n_checks++;
        if (o_req_cycles !== 0 || o_rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL rand_misalign[%0d]: got req %0d rdata %h expected 0 0", i, o_req_cycles,
                   o_rdata);
        end
      end else begin
        n_checks++;
        if (o_addr !== {a[31:2], 2'b00} || o_be !== exp_be || o_we !== ~rd) begin
          n_fail++;
          $display("FAIL rand_bus[%0d]: got addr %h be %b we %b expected %h %b %b", i, o_addr,
                   o_be, o_we, {a[31:2], 2'b00}, exp_be, ~rd);
        end
        n_checks++;
        if (rd && o_rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL rand_rdata[%0d]: f3 %b addr %h word %h got %h expected %h", i, f3, a,
                   rw, o_rdata, exp_rd);
        end else if (!rd && o_wdata !== exp_wd) begin
          n_fail++;
          $display("FAIL rand_wdata[%0d]: f3 %b wdata %h got %h expected %h", i, f3, wd, o_wdata,
                   exp_wd);
        end
      end
      idle(1 + int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_flush_drain();
    test_timeout();
    test_back_to_back();
    test_both_set();
    test_reset_mid();
`ifdef MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
